calc_operand_sequencer: RTL and testbench
=========================================

Name: calc_operand_sequencer

Overview:
Upstream stage of the 4-bit signed calculator. It debounces two raw board pushbuttons and steps the user through entering operand A, operand B and the 3-bit op code on SW. It then presents the captured {A, B, OP} set to the calculator over a valid/ready handshake. Registered outputs stay stable, so the calculator's HEX displays do not flicker while the switches move.

Parameters:
DATA_W, 4, operand width (two's complement)
OP_W, 3, op code width
DB_LIMIT, 1000000, debounce stable-count in clocks (20 ms at 50 MHz); benches override to 4
DB_CNT_W, 20, debounce counter width, must hold DB_LIMIT-1

Ports:
CLOCK_50  input  1  system clock
RESET  input  1  asynchronous, active-high reset
SW  input  8  raw switches; SW[3:0] operand value, SW[2:0] op value
KEY_ENTER  input  1  raw pushbutton, active-low (pressed = 0)
KEY_CLR  input  1  raw pushbutton, active-low
OUT_READY  input  1  calculator accepts the current set
A_OUT  output  4  captured operand A
B_OUT  output  4  captured operand B
OP_OUT  output  3  captured op code
OUT_VALID  output  1  {A_OUT, B_OUT, OP_OUT} complete and offered
STAGE  output  2  current FSM state, for LED display

Behaviour:
- Reset (async, active-high): A_OUT=0, B_OUT=0, OP_OUT=0, OUT_VALID=0, STAGE=WAIT_A. Both debouncers' stable level = 1 (released), counters = 0, SW sync flops = 0.
- SW path: 2-FF synchronizer. All captures use the synchronized SW in the capture cycle.
- Each key runs through key_debouncer:
  - 2-FF sync, then compare the synced level with the stable level.
  - Mismatch: counter increments. Match: counter clears.
  - Counter reaching DB_LIMIT-1 while still mismatched: stable <= synced, counter clears.
  - A stable 1->0 transition produces a one-cycle press pulse.
  - Latency from a clean raw low to the pulse: DB_LIMIT+3 clocks.
  - Glitches shorter than DB_LIMIT clocks produce no pulse. Release produces no pulse.
- FSM, encoding in package: WAIT_A=0, WAIT_B=1, WAIT_OP=2, ISSUE=3.
  - WAIT_A + enter pulse: A_OUT <= SW[3:0], go to WAIT_B.
  - WAIT_B + enter pulse: B_OUT <= SW[3:0], go to WAIT_OP.
  - WAIT_OP + enter pulse: OP_OUT <= SW[2:0], OUT_VALID <= 1, go to ISSUE.
  - ISSUE: A_OUT, B_OUT, OP_OUT and OUT_VALID are held. Enter pulses are ignored.
  - ISSUE, on the clock edge where OUT_READY=1: transfer occurs, OUT_VALID <= 0, go to WAIT_A. A_OUT, B_OUT and OP_OUT keep their values until overwritten.
  - OUT_READY is ignored outside ISSUE. OUT_VALID never asserts before the op is captured.
- Clear pulse, any state: go to WAIT_A, OUT_VALID <= 0. A_OUT, B_OUT and OP_OUT are unchanged. No transfer occurs, even if OUT_READY=1 in the same cycle.
- Clear and enter pulses in the same cycle: clear wins and nothing is captured.
- RESET asserted mid-entry or in ISSUE: immediate return to reset values. A debounce already in progress is lost. A key held through the RESET release gives a press pulse DB_LIMIT+3 clocks later.
- No arithmetic is performed here. Values pass through bit-exact; signedness is interpreted downstream.

Decomposition:
- Package calc_pkg:
  - state enum and encodings WAIT_A, WAIT_B, WAIT_OP, ISSUE
  - DATA_W and OP_W defaults
  - op code constants: ADD_AB=000, ADD_BA=100, SUB_AB=001, SUB_BA=101, ABS_B=010/011, ABS_A=110/111
- Sub-module key_debouncer (parameters DB_LIMIT, DB_CNT_W):
  - ports: CLOCK_50, RESET, raw_n, stable, press_pulse
  - instantiated twice, once for KEY_ENTER and once for KEY_CLR

Test Plan:
All scenarios use DB_LIMIT=4 and OUT_READY=0 unless stated.
- Full entry: SW=0100, press; SW=0011, press; SW=0000, press -> A_OUT=4, B_OUT=3, OP_OUT=000, OUT_VALID=1, STAGE=3. OUT_READY=1 for one cycle -> OUT_VALID=0 and STAGE=0 on the next cycle; A_OUT/B_OUT/OP_OUT still 4/3/000.
- Bounce rejection: KEY_ENTER low for 3 clocks then high, repeated 5 times -> no pulse, STAGE stays 0. A clean hold lasting DB_LIMIT+3 clocks -> exactly one capture.
- Held valid: in ISSUE with A=1001 (-7), B=1111 (-1), OP=001, change SW and press enter twice -> outputs unchanged, OUT_VALID stays 1 until OUT_READY=1.
- Clear priority: in WAIT_OP, deliver enter and clear pulses in the same cycle -> STAGE=0, OP_OUT unchanged, OUT_VALID=0. Clear in ISSUE with OUT_READY=1 in the same cycle -> OUT_VALID=0, STAGE=0.
- Reset mid-operation: assert RESET while in WAIT_B with KEY_ENTER held low -> all outputs 0 asynchronously. After release, with the key still held, exactly one pulse arrives DB_LIMIT+3 clocks later and A is captured.
- Signed boundaries: enter A=1000 (-8), B=0111 (7), OP=101 -> A_OUT=1000, B_OUT=0111, OP_OUT=101 bit-exact, OUT_VALID=1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the 4-bit signed calculator front end:
// operand-entry FSM states, data widths and op code encodings.
package calc_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        ISSUE   = 2'd3
    } stage_t;

    // Op codes as decoded by the calculator; bit 2 swaps the operand order.
    localparam logic [OP_W-1:0] ADD_AB    = 3'b000;
    localparam logic [OP_W-1:0] ADD_BA    = 3'b100;
    localparam logic [OP_W-1:0] SUB_AB    = 3'b001;
    localparam logic [OP_W-1:0] SUB_BA    = 3'b101;
    localparam logic [OP_W-1:0] ABS_B     = 3'b010;
    localparam logic [OP_W-1:0] ABS_B_ALT = 3'b011;
    localparam logic [OP_W-1:0] ABS_A     = 3'b110;
    localparam logic [OP_W-1:0] ABS_A_ALT = 3'b111;

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes and debounces one active-low pushbutton; emits a single-cycle
// pulse one clock after the debounced level falls (press), nothing on release.
module key_debouncer #(
    parameter int DB_LIMIT = 1000000,
    parameter int DB_CNT_W = 20
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic raw_n,
    output logic stable,
    output logic press_pulse
);

    localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);

    logic                sync1;
    logic                sync2;
    logic                stable_q;
    logic [DB_CNT_W-1:0] cnt;

    // Sync flops reset to the released level so a key held through reset
    // is seen as a fresh press once reset drops.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            stable_q    <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic, so
            // every flop samples pre-edge values regardless of statement order.
            sync1       <= raw_n;
            sync2       <= sync1;
            stable_q    <= stable;
            press_pulse <= stable_q & ~stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LIMIT_M1) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_operand_sequencer.sv
// Steps the user through entering A, B and the op code with debounced keys,
// then offers the captured set to the calculator over valid/ready.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int DB_LIMIT = 1000000,
    parameter int DB_CNT_W = 20
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [7:0]        SW,
    input  logic              KEY_ENTER,
    input  logic              KEY_CLR,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] A_OUT,
    output logic [DATA_W-1:0] B_OUT,
    output logic [OP_W-1:0]   OP_OUT,
    output logic              OUT_VALID,
    output logic [1:0]        STAGE
);

    stage_t            state, state_n;
    logic [DATA_W-1:0] sw_meta, sw_sync;
    logic [DATA_W-1:0] a_n, b_n;
    logic [OP_W-1:0]   op_n;
    logic              valid_n;
    logic              enter_pulse, clr_pulse;
    logic              enter_stable, clr_stable;

    // Upper switches and the debounced levels are not needed by this stage.
    logic unused_bits;
    assign unused_bits = &{1'b0, SW[7:DATA_W], enter_stable, clr_stable};

    key_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_enter_db (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .raw_n       (KEY_ENTER),
        .stable      (enter_stable),
        .press_pulse (enter_pulse)
    );

    key_debouncer #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) u_clr_db (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .raw_n       (KEY_CLR),
        .stable      (clr_stable),
        .press_pulse (clr_pulse)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sw_meta   <= '0;
            sw_sync   <= '0;
            state     <= WAIT_A;
            A_OUT     <= '0;
            B_OUT     <= '0;
            OP_OUT    <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            sw_meta   <= SW[DATA_W-1:0];
            sw_sync   <= sw_meta;
            state     <= state_n;
            A_OUT     <= a_n;
            B_OUT     <= b_n;
            OP_OUT    <= op_n;
            OUT_VALID <= valid_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_n = state;
        a_n     = A_OUT;
        b_n     = B_OUT;
        op_n    = OP_OUT;
        valid_n = OUT_VALID;
        // Clear outranks enter and an in-flight transfer; captured data is kept.
        if (clr_pulse) begin
            state_n = WAIT_A;
            valid_n = 1'b0;
        end else begin
            unique case (state)
                WAIT_A: if (enter_pulse) begin
                    a_n     = sw_sync;
                    state_n = WAIT_B;
                end
                WAIT_B: if (enter_pulse) begin
                    b_n     = sw_sync;
                    state_n = WAIT_OP;
                end
                WAIT_OP: if (enter_pulse) begin
                    op_n    = sw_sync[OP_W-1:0];
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end
                ISSUE: if (OUT_READY) begin
                    valid_n = 1'b0;
                    state_n = WAIT_A;
                end
                default: state_n = WAIT_A;
            endcase
        end
    end

    assign STAGE = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a short debounce window:
// table-driven full entries plus hand sequences for bounce, clear and reset.
module tb_calc_operand_sequencer;

    localparam int DB_LIMIT = 4;
    localparam int DB_CNT_W = 3;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [7:0] SW;
    logic       KEY_ENTER, KEY_CLR, OUT_READY;
    logic [3:0] A_OUT, B_OUT;
    logic [2:0] OP_OUT;
    logic       OUT_VALID;
    logic [1:0] STAGE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [2:0] exp_op;
    } vec_t;

    vec_t vecs[4];

    calc_operand_sequencer #(.DB_LIMIT(DB_LIMIT), .DB_CNT_W(DB_CNT_W)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .SW        (SW),
        .KEY_ENTER (KEY_ENTER),
        .KEY_CLR   (KEY_CLR),
        .OUT_READY (OUT_READY),
        .A_OUT     (A_OUT),
        .B_OUT     (B_OUT),
        .OP_OUT    (OP_OUT),
        .OUT_VALID (OUT_VALID),
        .STAGE     (STAGE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Hold the selected keys low long enough for one clean press, then release
    // long enough for the debouncers to settle back to the released level.
    task automatic press(input logic ent, input logic clr);
        @(negedge CLOCK_50);
        if (ent) KEY_ENTER = 1'b0;
        if (clr) KEY_CLR = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        KEY_ENTER = 1'b1;
        KEY_CLR   = 1'b1;
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic enter_set(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        SW = {4'h0, a};
        press(1'b1, 1'b0);
        SW = {4'h0, b};
        press(1'b1, 1'b0);
        SW = {5'h00, op};
        press(1'b1, 1'b0);
    endtask

    initial begin
        vecs[0] = '{a: 4'b0100, b: 4'b0011, op: 3'b000, exp_a: 4'h4, exp_b: 4'h3, exp_op: 3'b000};
        vecs[1] = '{a: 4'b1000, b: 4'b0111, op: 3'b101, exp_a: 4'h8, exp_b: 4'h7, exp_op: 3'b101};
        vecs[2] = '{a: 4'b1001, b: 4'b1111, op: 3'b001, exp_a: 4'h9, exp_b: 4'hf, exp_op: 3'b001};
        vecs[3] = '{a: 4'b1111, b: 4'b0000, op: 3'b111, exp_a: 4'hf, exp_b: 4'h0, exp_op: 3'b111};

        RESET = 1'b1; SW = 8'h00; KEY_ENTER = 1'b1; KEY_CLR = 1'b1; OUT_READY = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_a", A_OUT, 4'h0);
        check("reset_b", B_OUT, 4'h0);
        check("reset_op", OP_OUT, 3'h0);
        check("reset_valid", OUT_VALID, 1'b0);
        check("reset_stage", STAGE, 2'd0);
        RESET = 1'b0;

        // Full entries, each followed by a one-cycle OUT_READY transfer.
        for (int i = 0; i < 4; i++) begin
            SW = {4'h0, vecs[i].a};
            press(1'b1, 1'b0);
            check($sformatf("v%0d_stage_b", i), STAGE, 2'd1);
            check($sformatf("v%0d_a_early", i), A_OUT, vecs[i].exp_a);
            SW = {4'h0, vecs[i].b};
            press(1'b1, 1'b0);
            check($sformatf("v%0d_stage_op", i), STAGE, 2'd2);
            check($sformatf("v%0d_valid_early", i), OUT_VALID, 1'b0);
            SW = {5'h00, vecs[i].op};
            press(1'b1, 1'b0);
            check($sformatf("v%0d_a", i), A_OUT, vecs[i].exp_a);
            check($sformatf("v%0d_b", i), B_OUT, vecs[i].exp_b);
            check($sformatf("v%0d_op", i), OP_OUT, vecs[i].exp_op);
            check($sformatf("v%0d_valid", i), OUT_VALID, 1'b1);
            check($sformatf("v%0d_stage_issue", i), STAGE, 2'd3);
            OUT_READY = 1'b1;
            @(negedge CLOCK_50);
            OUT_READY = 1'b0;
            check($sformatf("v%0d_valid_done", i), OUT_VALID, 1'b0);
            check($sformatf("v%0d_stage_done", i), STAGE, 2'd0);
            check($sformatf("v%0d_a_kept", i), A_OUT, vecs[i].exp_a);
            check($sformatf("v%0d_b_kept", i), B_OUT, vecs[i].exp_b);
            check($sformatf("v%0d_op_kept", i), OP_OUT, vecs[i].exp_op);
        end

        // Bounce rejection: five 3-clock lows never reach the debounce limit.
        SW = 8'h05;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            KEY_ENTER = 1'b0;
            repeat (3) @(negedge CLOCK_50);
            KEY_ENTER = 1'b1;
            repeat (4) @(negedge CLOCK_50);
        end
        repeat (8) @(negedge CLOCK_50);
        check("bounce_stage", STAGE, 2'd0);
        check("bounce_a", A_OUT, 4'hf);
        // A clean hold of DB_LIMIT+3 clocks gives exactly one capture.
        KEY_ENTER = 1'b0;
        repeat (DB_LIMIT + 3) @(negedge CLOCK_50);
        KEY_ENTER = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("clean_stage", STAGE, 2'd1);
        check("clean_a", A_OUT, 4'h5);
        press(1'b0, 1'b1);
        check("clr_wait_b_stage", STAGE, 2'd0);

        // Held valid: enter presses in ISSUE are ignored.
        enter_set(4'b1001, 4'b1111, 3'b001);
        SW = 8'h06;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("held_a", A_OUT, 4'h9);
        check("held_b", B_OUT, 4'hf);
        check("held_op", OP_OUT, 3'b001);
        check("held_valid", OUT_VALID, 1'b1);
        check("held_stage", STAGE, 2'd3);
        OUT_READY = 1'b1;
        @(negedge CLOCK_50);
        OUT_READY = 1'b0;
        check("held_release_valid", OUT_VALID, 1'b0);

        // Clear and enter in the same cycle while in WAIT_OP: clear wins.
        SW = 8'h02;
        press(1'b1, 1'b0);
        SW = 8'h03;
        press(1'b1, 1'b0);
        check("prio_pre_stage", STAGE, 2'd2);
        SW = 8'h06;
        press(1'b1, 1'b1);
        check("prio_stage", STAGE, 2'd0);
        check("prio_op", OP_OUT, 3'b001);
        check("prio_valid", OUT_VALID, 1'b0);

        // Clear in ISSUE coinciding with OUT_READY.
        enter_set(4'b0010, 4'b0011, 3'b100);
        check("clr_issue_pre_valid", OUT_VALID, 1'b1);
        @(negedge CLOCK_50);
        KEY_CLR = 1'b0;
        repeat (DB_LIMIT + 3) @(negedge CLOCK_50);
        OUT_READY = 1'b1;
        @(negedge CLOCK_50);
        OUT_READY = 1'b0;
        check("clr_issue_valid", OUT_VALID, 1'b0);
        check("clr_issue_stage", STAGE, 2'd0);
        check("clr_issue_op", OP_OUT, 3'b100);
        repeat (4) @(negedge CLOCK_50);
        KEY_CLR = 1'b1;
        repeat (8) @(negedge CLOCK_50);

        // Reset mid-entry with the enter key held through the reset release.
        SW = 8'h05;
        press(1'b1, 1'b0);
        check("rst_pre_stage", STAGE, 2'd1);
        @(negedge CLOCK_50);
        KEY_ENTER = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_a", A_OUT, 4'h0);
        check("rst_async_b", B_OUT, 4'h0);
        check("rst_async_op", OP_OUT, 3'h0);
        check("rst_async_stage", STAGE, 2'd0);
        SW = 8'h0a;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (DB_LIMIT + 3) @(negedge CLOCK_50);
        check("rst_no_early_capture", STAGE, 2'd0);
        @(negedge CLOCK_50);
        check("rst_capture_stage", STAGE, 2'd1);
        check("rst_capture_a", A_OUT, 4'ha);
        repeat (12) @(negedge CLOCK_50);
        check("rst_single_pulse", STAGE, 2'd1);
        KEY_ENTER = 1'b1;
        repeat (8) @(negedge CLOCK_50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
